// File: rtl/ahb_master_arb_if.sv
// ahb_master_arb_if
//
// Bundle of every AHB-Lite signal between N upstream masters, the arbiter
// and the single downstream slave port. Per-master signals are flattened
// vectors, with master i occupying slice i (e.g. HTRANS_M[2i+1:2i]).
//
// Modports:
//   slave  - the arbiter's view. It receives the master requests and the
//            slave response, and drives the per-master HREADY, the
//            broadcast response and the muxed slave-side request.
//   master - the environment's view. The masters and the downstream slave
//            model drive what the arbiter consumes.
interface ahb_master_arb_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Upstream master side
    logic [2*NUM_MASTERS-1:0]      HTRANS_M;
    logic [NUM_MASTERS-1:0]        HWRITE_M;
    logic [3*NUM_MASTERS-1:0]      HSIZE_M;
    logic [ADDR_W*NUM_MASTERS-1:0] HADDR_M;
    logic [DATA_W*NUM_MASTERS-1:0] HWDATA_M;
    logic [NUM_MASTERS-1:0]        HLOCK_M;
    logic [NUM_MASTERS-1:0]        HREADY_M;
    logic                          HRESP_M;
    logic [DATA_W-1:0]             HRDATA_M;

    // Downstream slave side
    logic [1:0]                    HTRANS_S;
    logic                          HWRITE_S;
    logic [2:0]                    HSIZE_S;
    logic [ADDR_W-1:0]             HADDR_S;
    logic [DATA_W-1:0]             HWDATA_S;
    logic                          HMASTLOCK_S;
    logic                          HREADY_S;
    logic                          HRESP_S;
    logic [DATA_W-1:0]             HRDATA_S;

    // Current address-phase owner
    logic [MW-1:0]                 HMASTER;

    modport slave (
        input  HTRANS_M, HWRITE_M, HSIZE_M, HADDR_M, HWDATA_M, HLOCK_M,
        input  HREADY_S, HRESP_S, HRDATA_S,
        output HREADY_M, HRESP_M, HRDATA_M,
        output HTRANS_S, HWRITE_S, HSIZE_S, HADDR_S, HWDATA_S, HMASTLOCK_S,
        output HMASTER
    );

    modport master (
        output HTRANS_M, HWRITE_M, HSIZE_M, HADDR_M, HWDATA_M, HLOCK_M,
        output HREADY_S, HRESP_S, HRDATA_S,
        input  HREADY_M, HRESP_M, HRDATA_M,
        input  HTRANS_S, HWRITE_S, HSIZE_S, HADDR_S, HWDATA_S, HMASTLOCK_S,
        input  HMASTER
    );
endinterface

// File: rtl/ahb_master_arb.sv
// ahb_master_arb
//
// N-master AHB-Lite arbiter and mux feeding one downstream slave port. The
// block chooses the bus owner itself (fixed priority or round-robin), keeps
// address-phase and data-phase ownership apart, honours locked sequences
// and stalls every non-owner by holding its HREADY low.
//
// Ports:
//   HCLK    - bus clock, rising edge
//   HRESET  - synchronous, active-high reset
//   bus     - ahb_master_arb_if.slave: per-master requests in, per-master
//             HREADY plus broadcast HRESP/HRDATA out, muxed request to the
//             downstream slave out, slave response in, HMASTER out
module ahb_master_arb #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int PARK_LAST      = 1
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_master_arb_if.slave   bus
);
    localparam int         MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [MW-1:0] DEF_OWNER = MW'(DEFAULT_MASTER);

    generate
        if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
            $error("ahb_master_arb: NUM_MASTERS must be 1..8");
        end
        if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
            $error("ahb_master_arb: DEFAULT_MASTER must be < NUM_MASTERS");
        end
    endgenerate

    logic [MW-1:0]          owner_q;
    logic [MW-1:0]          owner_d;
    logic [MW-1:0]          d_owner_q;
    logic                   d_valid_q;

    logic [NUM_MASTERS-1:0] req;
    logic [1:0]             own_trans;
    logic                   own_write;
    logic [2:0]             own_size;
    logic [ADDR_W-1:0]      own_addr;
    logic                   own_lock;
    logic [DATA_W-1:0]      d_wdata;

    logic [MW-1:0]          pick;
    logic                   pick_found;
    logic                   handover;

    // Index reached by stepping 'step' places cyclically past 'base'.
    function automatic int wrap_next(input logic [MW-1:0] base, input int step);
        int c;
        c = int'(base) + step;
        if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
        return c;
    endfunction

    // Address-phase fields follow owner; write data follows the data-phase
    // owner, which lags owner by one accepted transfer.
    always_comb begin
        req       = '0;
        own_trans = HTRANS_IDLE;
        own_write = 1'b0;
        own_size  = 3'b000;
        own_addr  = '0;
        own_lock  = 1'b0;
        d_wdata   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = bus.HTRANS_M[2*i+1];
            if (owner_q == MW'(i)) begin
                own_trans = bus.HTRANS_M[2*i +: 2];
                own_write = bus.HWRITE_M[i];
                own_size  = bus.HSIZE_M[3*i +: 3];
                own_addr  = bus.HADDR_M[ADDR_W*i +: ADDR_W];
                own_lock  = bus.HLOCK_M[i];
            end
            if (d_owner_q == MW'(i)) begin
                d_wdata = bus.HWDATA_M[DATA_W*i +: DATA_W];
            end
        end
    end

    // Only the owner ever sees the slave's HREADY; everyone else is stalled.
    always_comb begin
        bus.HREADY_M = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.HREADY_M[i] = bus.HREADY_S && (owner_q == MW'(i));
        end
    end

    // While reset is held the owner's request must not reach the slave.
    assign bus.HTRANS_S    = HRESET ? HTRANS_IDLE : own_trans;
    assign bus.HMASTLOCK_S = !HRESET && own_lock;
    assign bus.HWRITE_S    = own_write;
    assign bus.HSIZE_S     = own_size;
    assign bus.HADDR_S     = own_addr;
    assign bus.HWDATA_S    = d_wdata;
    assign bus.HRESP_M     = bus.HRESP_S;
    assign bus.HRDATA_M    = bus.HRDATA_S;
    assign bus.HMASTER     = owner_q;

    // Candidate for the next owner. Fixed priority: the lowest requesting
    // index (the descending scan lets lower indices overwrite). Round-robin:
    // the first requester cyclically after the owner, the owner itself last.
    always_comb begin
        pick       = owner_q;
        pick_found = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    pick       = MW'(i);
                    pick_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!pick_found && req[i] && (wrap_next(owner_q, k) == i)) begin
                        pick       = MW'(i);
                        pick_found = 1'b1;
                    end
                end
            end
        end
    end

    // Ownership only moves when the owner has an IDLE address phase accepted
    // and is not locked, so a burst, BUSY or pending NONSEQ is never cut.
    always_comb begin
        owner_d  = owner_q;
        handover = bus.HREADY_S && (own_trans == HTRANS_IDLE) && !own_lock;
        if (handover) begin
            if (pick_found) begin
                owner_d = pick;
            end else if (PARK_LAST == 0) begin
                owner_d = DEF_OWNER;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner_q   <= DEF_OWNER;
            d_owner_q <= DEF_OWNER;
            d_valid_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            if (bus.HREADY_S) begin
                d_owner_q <= owner_q;
                d_valid_q <= bus.HTRANS_S[1];
            end
        end
    end

    // A handover always follows an accepted IDLE, so a changed owner can
    // never coincide with a live data phase.
    a_handover_clears_data_phase: assert property (
        @(posedge HCLK) disable iff (HRESET)
        (owner_q != $past(owner_q)) |-> !d_valid_q
    );
endmodule

// File: tb/tb_ahb_master_arb.sv
// tb_ahb_master_arb
//
// Two arbiters with NUM_MASTERS = 4 and DEFAULT_MASTER = 2 share one set of
// master/slave stimulus:
//   dut_a: round-robin, keeps the last owner when idle
//   dut_b: fixed priority, parks on DEFAULT_MASTER when idle
// Each scenario starts from reset. The stimulus pushes hand-computed
// expectations into a scoreboard queue tagged with the current cycle; a
// separate monitor pops and compares them on the falling edge.
module tb_ahb_master_arb;
    localparam int N = 4;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam int K_MASTER = 0;
    localparam int K_READY  = 1;
    localparam int K_TRANS  = 2;
    localparam int K_ADDR   = 3;
    localparam int K_WDATA  = 4;
    localparam int K_LOCK   = 5;
    localparam int K_RESP   = 6;
    localparam int K_RDATA  = 7;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    logic [2*N-1:0]  htrans_bus;
    logic [N-1:0]    hwrite_bus;
    logic [32*N-1:0] haddr_bus;
    logic [32*N-1:0] hwdata_bus;
    logic [N-1:0]    hlock_bus;
    logic            hready_s;
    logic            hresp_s;
    logic [31:0]     hrdata_s;

    ahb_master_arb_if #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32)) ifa ();
    ahb_master_arb_if #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32)) ifb ();

    assign ifa.HTRANS_M = htrans_bus;
    assign ifa.HWRITE_M = hwrite_bus;
    assign ifa.HSIZE_M  = {N{3'b010}};
    assign ifa.HADDR_M  = haddr_bus;
    assign ifa.HWDATA_M = hwdata_bus;
    assign ifa.HLOCK_M  = hlock_bus;
    assign ifa.HREADY_S = hready_s;
    assign ifa.HRESP_S  = hresp_s;
    assign ifa.HRDATA_S = hrdata_s;

    assign ifb.HTRANS_M = htrans_bus;
    assign ifb.HWRITE_M = hwrite_bus;
    assign ifb.HSIZE_M  = {N{3'b010}};
    assign ifb.HADDR_M  = haddr_bus;
    assign ifb.HWDATA_M = hwdata_bus;
    assign ifb.HLOCK_M  = hlock_bus;
    assign ifb.HREADY_S = hready_s;
    assign ifb.HRESP_S  = hresp_s;
    assign ifb.HRDATA_S = hrdata_s;

    ahb_master_arb #(
        .NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32),
        .ARB_MODE(1), .DEFAULT_MASTER(2), .PARK_LAST(1)
    ) dut_a (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (ifa)
    );

    ahb_master_arb #(
        .NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32),
        .ARB_MODE(0), .DEFAULT_MASTER(2), .PARK_LAST(0)
    ) dut_b (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (ifb)
    );

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int kind);
        logic [31:0] v;
        v = 32'hFFFF_FFFF;
        if (dut == 0) begin
            case (kind)
                K_MASTER: v = 32'(ifa.HMASTER);
                K_READY:  v = 32'(ifa.HREADY_M);
                K_TRANS:  v = 32'(ifa.HTRANS_S);
                K_ADDR:   v = ifa.HADDR_S;
                K_WDATA:  v = ifa.HWDATA_S;
                K_LOCK:   v = 32'(ifa.HMASTLOCK_S);
                K_RESP:   v = 32'(ifa.HRESP_M);
                K_RDATA:  v = ifa.HRDATA_M;
                default:  v = 32'hFFFF_FFFF;
            endcase
        end else begin
            case (kind)
                K_MASTER: v = 32'(ifb.HMASTER);
                K_READY:  v = 32'(ifb.HREADY_M);
                K_TRANS:  v = 32'(ifb.HTRANS_S);
                K_ADDR:   v = ifb.HADDR_S;
                K_WDATA:  v = ifb.HWDATA_S;
                K_LOCK:   v = 32'(ifb.HMASTLOCK_S);
                K_RESP:   v = 32'(ifb.HRESP_M);
                K_RDATA:  v = ifb.HRDATA_M;
                default:  v = 32'hFFFF_FFFF;
            endcase
        end
        return v;
    endfunction

    // Monitor: every expectation queued for this cycle is compared mid-cycle.
    always @(negedge HCLK) begin
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            got = actual(e.dut, e.kind);
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("[TB] FAIL %s: expectation for cycle %0d checked late at cycle %0d",
                         e.name, e.cyc, cyc);
            end else if (got !== e.exp) begin
                fails++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_output(input int dut, input int kind, input logic [31:0] exp,
                                input string name);
        sb.push_back('{cyc, dut, kind, exp, name});
    endtask

    task automatic apply_stimulus(input int i, input logic [1:0] trans, input logic write,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic lock);
        htrans_bus[2*i +: 2] = trans;
        hwrite_bus[i]        = write;
        haddr_bus[32*i +: 32]  = addr;
        hwdata_bus[32*i +: 32] = wdata;
        hlock_bus[i]         = lock;
    endtask

    // Leaves both arbiters in reset state with HRESET already released.
    task automatic do_reset();
        htrans_bus = '0;
        hwrite_bus = '0;
        haddr_bus  = '0;
        hwdata_bus = '0;
        hlock_bus  = '0;
        hready_s   = 1'b1;
        hresp_s    = 1'b0;
        hrdata_s   = '0;
        HRESET     = 1'b1;
        tick();
        tick();
        HRESET     = 1'b0;
    endtask

    initial begin
        // Reset: owner is DEFAULT_MASTER and the request is masked.
        htrans_bus = '0;
        hwrite_bus = '0;
        haddr_bus  = '0;
        hwdata_bus = '0;
        hlock_bus  = '0;
        hready_s   = 1'b1;
        hresp_s    = 1'b0;
        hrdata_s   = '0;
        HRESET     = 1'b1;
        tick();
        apply_stimulus(2, NONSEQ, 1'b0, 32'h0000_2000, 32'h0, 1'b1);
        check_output(0, K_MASTER, 32'd2,     "rst hmaster A");
        check_output(1, K_MASTER, 32'd2,     "rst hmaster B");
        check_output(0, K_TRANS,  32'd0,     "rst htrans forced idle");
        check_output(0, K_LOCK,   32'd0,     "rst hmastlock forced 0");
        check_output(0, K_READY,  32'b0100,  "rst hready_m");
        tick();

        // Round-robin handover 0 -> 1 -> 3 on dut_a.
        do_reset();
        apply_stimulus(0, NONSEQ, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        tick();
        check_output(0, K_MASTER, 32'd0,          "rr m0 granted");
        check_output(0, K_ADDR,   32'h0000_0040,  "rr m0 haddr");
        tick();
        apply_stimulus(0, IDLE,   1'b0, 32'h0,        32'h0, 1'b0);
        apply_stimulus(1, NONSEQ, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
        apply_stimulus(3, NONSEQ, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
        check_output(0, K_MASTER, 32'd0,     "rr m0 still owner");
        check_output(0, K_READY,  32'b0001,  "rr m1 m3 stalled");
        check_output(0, K_TRANS,  32'd0,     "rr m0 idle on bus");
        tick();
        check_output(0, K_MASTER, 32'd1,          "rr m1 granted");
        check_output(0, K_ADDR,   32'h0000_1000,  "rr m1 haddr");
        check_output(0, K_READY,  32'b0010,       "rr m1 ready");
        tick();
        apply_stimulus(1, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        check_output(0, K_MASTER, 32'd1,     "rr m1 idle owner");
        check_output(0, K_READY,  32'b0010,  "rr m3 still stalled");
        tick();
        check_output(0, K_MASTER, 32'd3,          "rr m3 granted");
        check_output(0, K_ADDR,   32'h0000_3000,  "rr m3 haddr");
        check_output(0, K_READY,  32'b1000,       "rr m3 ready");
        tick();
        apply_stimulus(3, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // INCR4 write burst by m0 with a wait state; m2 waits for the IDLE.
        do_reset();
        apply_stimulus(0, NONSEQ, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
        tick();
        apply_stimulus(2, NONSEQ, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
        check_output(0, K_MASTER, 32'd0,         "burst m0 owner");
        check_output(0, K_ADDR,   32'h0000_0100, "burst beat1 haddr");
        tick();
        apply_stimulus(0, SEQ, 1'b1, 32'h0000_0104, 32'h0000_00D1, 1'b0);
        check_output(0, K_WDATA,  32'h0000_00D1, "burst beat1 hwdata");
        check_output(0, K_READY,  32'b0001,      "burst m2 stalled");
        tick();
        apply_stimulus(0, SEQ, 1'b1, 32'h0000_0108, 32'h0000_00D2, 1'b0);
        hready_s = 1'b0;
        check_output(0, K_WDATA,  32'h0000_00D2, "burst beat2 hwdata");
        check_output(0, K_READY,  32'b0000,      "burst wait state");
        check_output(0, K_ADDR,   32'h0000_0108, "burst beat3 haddr");
        tick();
        hready_s = 1'b1;
        check_output(0, K_WDATA,  32'h0000_00D2, "burst beat2 hwdata held");
        check_output(0, K_MASTER, 32'd0,         "burst no preempt");
        tick();
        apply_stimulus(0, SEQ, 1'b1, 32'h0000_010C, 32'h0000_00D3, 1'b0);
        check_output(0, K_WDATA,  32'h0000_00D3, "burst beat3 hwdata");
        tick();
        apply_stimulus(0, IDLE, 1'b0, 32'h0, 32'h0000_00D4, 1'b0);
        check_output(0, K_WDATA,  32'h0000_00D4, "burst beat4 hwdata");
        check_output(0, K_MASTER, 32'd0,         "burst m0 owns idle");
        tick();
        check_output(0, K_MASTER, 32'd2,         "burst m2 granted");
        check_output(0, K_ADDR,   32'h0000_2000, "burst m2 haddr");
        check_output(0, K_TRANS,  32'd2,         "burst m2 nonseq");
        check_output(0, K_READY,  32'b0100,      "burst m2 ready");
        tick();
        apply_stimulus(2, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Locked sequence by m1 on fixed-priority dut_b.
        do_reset();
        apply_stimulus(1, NONSEQ, 1'b0, 32'h0000_1100, 32'h0, 1'b1);
        tick();
        apply_stimulus(0, NONSEQ, 1'b0, 32'h0000_0500, 32'h0, 1'b0);
        check_output(1, K_MASTER, 32'd1,         "lock m1 granted");
        check_output(1, K_LOCK,   32'd1,         "lock hmastlock on");
        check_output(1, K_ADDR,   32'h0000_1100, "lock first haddr");
        tick();
        apply_stimulus(1, IDLE, 1'b0, 32'h0, 32'h0, 1'b1);
        check_output(1, K_MASTER, 32'd1,         "lock held over idle");
        check_output(1, K_LOCK,   32'd1,         "lock hmastlock idle");
        check_output(1, K_READY,  32'b0010,      "lock m0 stalled");
        tick();
        apply_stimulus(1, NONSEQ, 1'b0, 32'h0000_1104, 32'h0, 1'b1);
        check_output(1, K_MASTER, 32'd1,         "lock second transfer");
        check_output(1, K_ADDR,   32'h0000_1104, "lock second haddr");
        tick();
        apply_stimulus(1, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        check_output(1, K_MASTER, 32'd1,         "lock released owner");
        check_output(1, K_LOCK,   32'd0,         "lock hmastlock off");
        tick();
        check_output(1, K_MASTER, 32'd0,         "lock m0 granted");
        check_output(1, K_ADDR,   32'h0000_0500, "lock m0 haddr");
        check_output(1, K_READY,  32'b0001,      "lock m0 ready");
        tick();
        apply_stimulus(0, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Two-cycle ERROR response to m2; handover on the second cycle.
        do_reset();
        apply_stimulus(2, NONSEQ, 1'b0, 32'h0000_2200, 32'h0, 1'b0);
        apply_stimulus(1, NONSEQ, 1'b0, 32'h0000_1200, 32'h0, 1'b0);
        check_output(0, K_MASTER, 32'd2,         "err m2 owner");
        tick();
        apply_stimulus(2, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        hresp_s  = 1'b1;
        hready_s = 1'b0;
        check_output(0, K_RESP,   32'd1,         "err cycle1 hresp");
        check_output(0, K_READY,  32'b0000,      "err cycle1 hready");
        check_output(0, K_MASTER, 32'd2,         "err cycle1 owner");
        tick();
        hready_s = 1'b1;
        hrdata_s = 32'hDEAD_BEEF;
        check_output(0, K_RESP,   32'd1,         "err cycle2 hresp");
        check_output(0, K_READY,  32'b0100,      "err cycle2 hready");
        check_output(0, K_RDATA,  32'hDEAD_BEEF, "err hrdata broadcast");
        tick();
        hresp_s = 1'b0;
        check_output(0, K_MASTER, 32'd1,         "err m1 granted");
        check_output(0, K_ADDR,   32'h0000_1200, "err m1 haddr");
        check_output(0, K_RESP,   32'd0,         "err hresp cleared");
        tick();
        apply_stimulus(1, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Parking: dut_b returns to DEFAULT_MASTER, dut_a keeps m3.
        do_reset();
        apply_stimulus(3, NONSEQ, 1'b0, 32'h0000_3300, 32'h0, 1'b0);
        tick();
        check_output(0, K_MASTER, 32'd3, "park A m3 granted");
        check_output(1, K_MASTER, 32'd3, "park B m3 granted");
        tick();
        apply_stimulus(3, IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        check_output(1, K_MASTER, 32'd3, "park B m3 idle owner");
        tick();
        check_output(1, K_MASTER, 32'd2, "park B default");
        check_output(0, K_MASTER, 32'd3, "park A keeps last");
        tick();
        check_output(1, K_MASTER, 32'd2, "park B stays default");
        check_output(0, K_MASTER, 32'd3, "park A stays last");
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_master_arb.md
Name: ahb_master_arb

Overview:
- Parametrised N-master AHB-Lite arbiter/mux feeding one downstream AHB-Lite slave port (interconnect or decoder).
- Unlike externally-selected muxes, it decides ownership itself (fixed-priority or round-robin).
- Supports locked sequences and tracks address/data-phase ownership separately.
- Non-granted masters are stalled with HREADY low.

Parameters:
- NUM_MASTERS, 4, number of master ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- DEFAULT_MASTER, 0, owner after reset and park target; must be < NUM_MASTERS (elaboration error otherwise).
- PARK_LAST, 1, 1 = keep last owner when nobody requests, 0 = park on DEFAULT_MASTER.

Ports:
- HCLK  in  1  bus clock, rising-edge.
- HRESET  in  1  synchronous, active-high reset.
- HTRANS_M  in  2*NUM_MASTERS  per-master HTRANS, master i at [2i+1:2i].
- HWRITE_M  in  NUM_MASTERS  per-master HWRITE.
- HSIZE_M  in  3*NUM_MASTERS  per-master HSIZE.
- HADDR_M  in  ADDR_W*NUM_MASTERS  per-master HADDR.
- HWDATA_M  in  DATA_W*NUM_MASTERS  per-master HWDATA.
- HLOCK_M  in  NUM_MASTERS  per-master lock request.
- HREADY_M  out  NUM_MASTERS  per-master HREADY.
- HRESP_M  out  1  HRESP broadcast to all masters.
- HRDATA_M  out  DATA_W  HRDATA broadcast to all masters.
- HTRANS_S  out  2  to slave.
- HWRITE_S  out  1  to slave.
- HSIZE_S  out  3  to slave.
- HADDR_S  out  ADDR_W  to slave.
- HWDATA_S  out  DATA_W  to slave.
- HMASTLOCK_S  out  1  to slave.
- HREADY_S  in  1  from slave.
- HRESP_S  in  1  from slave.
- HRDATA_S  in  DATA_W  from slave.
- HMASTER  out  max(1,$clog2(NUM_MASTERS))  current address-phase owner.

Behaviour:
- Interface: one clock HCLK; reset HRESET is synchronous and active-high.
- State registers:
  - owner: address-phase grant.
  - d_owner and d_valid: data-phase owner and whether that data phase is a real transfer.
- Reset (HRESET high at a rising edge): owner = d_owner = DEFAULT_MASTER, d_valid = 0. While HRESET is high, HTRANS_S is forced to IDLE and HMASTLOCK_S to 0.
- Address mux (combinational on owner): HTRANS_S, HWRITE_S, HSIZE_S, HADDR_S and HMASTLOCK_S = HLOCK_M[owner]. HMASTER = owner.
- Data mux: HWDATA_S = HWDATA_M[d_owner].
- HREADY_M[i] = HREADY_S if i == owner, else 0. HRESP_M and HRDATA_M are straight broadcasts of HRESP_S and HRDATA_S.
- Data-phase tracking: on a rising edge with HREADY_S = 1, d_owner <= owner and d_valid <= HTRANS_S[1]. With HREADY_S = 0, both hold.
- Request: master i requests when HTRANS_M[i][1] = 1 (NONSEQ/SEQ).
- Handover point: a rising edge where HREADY_S = 1, HTRANS_M[owner] = IDLE and HLOCK_M[owner] = 0. At any other edge, owner holds.
  - The owner is therefore never pre-empted mid-burst, during BUSY, while locked, or while it presents NONSEQ; no transfer is ever dropped or replayed.
- Next owner at a handover point:
  - Fixed priority: lowest requesting index.
  - Round-robin: first requesting index cyclically after the current owner (owner+1 ... owner-1, then owner).
  - No requester: owner unchanged if PARK_LAST = 1, else DEFAULT_MASTER.
- Latency:
  - A master that already owns the bus and issues NONSEQ: 0 extra cycles.
  - A non-owner request seen at a handover edge: owns from the next cycle, so its NONSEQ is stalled exactly 1 cycle (HREADY_M low).
  - A non-owner waits indefinitely while the owner never idles; this is documented, and fairness relies on masters idling.
- Handover cycle: the previous owner's last accepted transfer is IDLE, so after handover d_valid = 0 and no master loses a data phase. The old owner sees HREADY 0 from then on.
- ERROR response: both cycles go to the owner. Handover is allowed on the second cycle if the master drives IDLE there.
- NUM_MASTERS = 1: owner is constant 0, HREADY_M[0] = HREADY_S, HMASTER = 0.
- Reset mid-burst: state returns to reset values at the next edge regardless of HREADY_S.

Test Plan:
- Reset with NUM_MASTERS = 4, DEFAULT_MASTER = 2 -> HMASTER = 2, HTRANS_S = IDLE during reset, HREADY_M = 4'b0100 when HREADY_S = 1.
- M0 idle owner, M1 and M3 drive NONSEQ to 0x1000 and 0x3000, ARB_MODE = 1 -> M1 granted next cycle with HADDR_S = 0x1000. After M1 idles, M3 granted with HADDR_S = 0x3000. M3 sees HREADY low for exactly 2 extra cycles.
- M0 INCR4 write burst with M2 requesting and HREADY_S low 1 cycle on beat 2 -> no handover until M0 IDLE; HWDATA_S follows d_owner = 0 for all 4 beats; M2 granted 1 cycle after M0's IDLE is accepted.
- HLOCK_M[1] = 1 across two SINGLE transfers separated by IDLE, M0 requesting, ARB_MODE = 0 -> grant stays on 1 and HMASTLOCK_S = 1 until HLOCK_M[1] drops, then M0 granted.
- Slave ERROR (HRESP_S = 1, HREADY_S 0 then 1) on M2 read, M2 drives IDLE in the second cycle -> HRESP_M = 1 in both cycles, handover allowed on the second cycle's edge.
- No requests, PARK_LAST = 0, owner 3 -> HMASTER = DEFAULT_MASTER one cycle after M3 idles. With PARK_LAST = 1, HMASTER stays 3.
